// File: rtl/imem_loader.sv
// imem_loader: program loader on the write side of the instruction memory.
// Accepts a byte stream over valid/ready and packs it into big-endian 32-bit
// words. Each word is written to the next word address, starting at 0. The
// CPU is held in reset until the whole program has been loaded.
// Optional feature macro: CHECKSUM_EN. When it is defined, a 32-bit sum of
// the written words is compared against 4 trailing stream bytes, and err
// reports a mismatch.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [31:0]           wd,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_hold,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE,
        S_WRITE,
        S_CHK,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] ONE = 1;

    state_t                state;
    state_t                state_nx;
    logic [1:0]            byte_cnt;
    logic [23:0]           pack;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [ADDR_WIDTH:0]   total;
    logic [ADDR_WIDTH:0]   word_next;
    logic                  accept_start;
    logic                  xfer;
    logic                  last_byte;
    logic                  last_word;

    assign accept_start = start && ((state == S_IDLE) || (state == S_DONE));
    assign in_ready     = (state == S_BYTE) || (state == S_CHK);
    assign xfer         = in_valid && in_ready;
    assign last_byte    = xfer && (byte_cnt == 2'd3);
    assign word_next    = word_cnt + ONE;
    assign last_word    = (word_next == total);

    assign we       = (state == S_WRITE);
    assign busy     = (state == S_BYTE) || (state == S_WRITE) || (state == S_CHK);
    assign cpu_hold = busy;
    assign done     = (state == S_DONE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a zero-length load goes straight to DONE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept_start) begin
                    state_nx = (count == '0) ? S_DONE : S_BYTE;
                end
            end
            S_BYTE: begin
                if (last_byte) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!last_word) begin
                    state_nx = S_BYTE;
                end else begin
`ifdef CHECKSUM_EN
                    state_nx = S_CHK;
`else
                    state_nx = S_DONE;
`endif
                end
            end
            S_CHK: begin
                if (last_byte) begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef CHECKSUM_EN
    logic [31:0] sum;
    logic        err_q;

    // Checksum accumulator; the trailing 4 bytes are compared against the sum
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept_start) begin
                sum   <= '0;
                err_q <= 1'b0;
            end
            if (state == S_WRITE) begin
                sum <= sum + wd;
            end
            if (last_byte && (state == S_CHK)) begin
                err_q <= ({pack, in_data} != sum);
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Byte packing, word counting and the write port. wa/wd only change on
    // the 4th byte of a word, so they are stable in WRITE and hold afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= '0;
            pack     <= '0;
            word_cnt <= '0;
            total    <= '0;
            wa       <= '0;
            wd       <= '0;
        end else begin
            if (accept_start) begin
                total    <= count;
                word_cnt <= '0;
                byte_cnt <= '0;
            end
            if (xfer) begin
                byte_cnt <= byte_cnt + 2'd1;
                pack     <= {pack[15:0], in_data};
                if (last_byte && (state == S_BYTE)) begin
                    wa <= word_cnt[ADDR_WIDTH-1:0];
                    wd <= {pack, in_data};
                end
            end
            if (state == S_WRITE) begin
                word_cnt <= word_next;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Bytes are driven at the falling edge and outputs are sampled there too.
// When CHECKSUM_EN is defined, every load is followed by its checksum word.
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   count = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic          busy;
    logic          done;
    logic          cpu_hold;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [AW-1:0] qa[$];
    logic [31:0]   qd[$];
    int            qt[$];
    logic [31:0]   wbuf[1024];

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .count    (count),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .busy     (busy),
        .done     (done),
        .cpu_hold (cpu_hold),
        .err      (err)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor plus invariants checked every cycle
    always @(negedge clk) begin
        if (reset_n) begin
            if (we === 1'b1) begin
                qa.push_back(wa);
                qd.push_back(wd);
                qt.push_back(cyc);
            end
            n_checks++;
            if (cpu_hold !== busy) begin
                n_fail++;
                $display("[TB] FAIL hold_tracks_busy: cpu_hold=%b busy=%b", cpu_hold, busy);
            end
            n_checks++;
            if ((in_ready & we) !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL ready_in_write: in_ready=%b we=%b, required not both 1", in_ready, we);
            end
        end
    end

    // Global time limit
    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic clear_writes();
        qa.delete();
        qd.delete();
        qt.delete();
    endtask

    task automatic pulse_start(input logic [AW:0] n);
        start = 1'b1;
        count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL byte_accept: in_ready never rose for byte %h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        while (done !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL %s_done: done=%b, required 1", tag, done);
        end
    endtask

    task automatic send_checksum(input logic [31:0] s, input int maxgap);
`ifdef CHECKSUM_EN
        send_word(s, maxgap);
`else
        if (s == 32'hFFFF_FFFF && maxgap < 0) begin
            $display("[TB] unreachable");
        end
`endif
    endtask

    task automatic run_load(input int n, input int maxgap, input string tag);
        logic [31:0] s = '0;
        logic [AW:0] nn = n[AW:0];
        clear_writes();
        pulse_start(nn);
        for (int i = 0; i < n; i++) begin
            send_word(wbuf[i], maxgap);
            s = s + wbuf[i];
        end
        send_checksum(s, maxgap);
        wait_done(tag);
    endtask

    task automatic test_reset();
        clear_writes();
        pulse_start(11'd1);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, we, busy, done, cpu_hold, err} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: ready,we,busy,done,hold,err=%b, required 000000",
                     {in_ready, we, busy, done, cpu_hold, err});
        end
        n_checks++;
        if (wa !== '0 || wd !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_bus: wa=%h wd=%h, required 0/0", wa, wd);
        end
        reset_n = 1'b1;
        @(negedge clk);
        wbuf[0] = 32'h1122_3344;
        run_load(1, 0, "reset_reload");
        n_checks++;
        if (qa.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL reset_reload_count: writes=%0d, required 1", qa.size());
        end else begin
            n_checks++;
            if (qa[0] !== 10'd0 || qd[0] !== 32'h1122_3344) begin
                n_fail++;
                $display("[TB] FAIL reset_reload_word: wa=%h wd=%h, required 000/11223344", qa[0], qd[0]);
            end
        end
    endtask

    task automatic check_three(input string tag);
        n_checks++;
        if (qa.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL %s_count: writes=%0d, required 3", tag, qa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (qa[i] !== i[AW-1:0] || qd[i] !== wbuf[i]) begin
                    n_fail++;
                    $display("[TB] FAIL %s_word%0d: wa=%h wd=%h, required %h/%h",
                             tag, i, qa[i], qd[i], i[AW-1:0], wbuf[i]);
                end
            end
        end
        n_checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s_end: busy=%b hold=%b err=%b, required 0/0/0", tag, busy, cpu_hold, err);
        end
    endtask

    task automatic test_back_to_back();
        wbuf[0] = 32'hAABB_CCDD;
        wbuf[1] = 32'h1234_5678;
        wbuf[2] = 32'hDEAD_BEEF;
        run_load(3, 0, "b2b");
        check_three("b2b");
        if (qt.size() == 3) begin
            n_checks++;
            if (qt[1] - qt[0] != 5 || qt[2] - qt[1] != 5) begin
                n_fail++;
                $display("[TB] FAIL b2b_spacing: gaps=%0d,%0d, required 5,5", qt[1] - qt[0], qt[2] - qt[1]);
            end
`ifndef CHECKSUM_EN
            n_checks++;
            if (cyc - qt[2] != 1) begin
                n_fail++;
                $display("[TB] FAIL b2b_done_latency: %0d cycles after last we, required 1", cyc - qt[2]);
            end
`endif
        end
        n_checks++;
        if (wa !== 10'd2 || wd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("[TB] FAIL b2b_hold: wa=%h wd=%h, required 002/deadbeef", wa, wd);
        end
    endtask

    task automatic test_gaps();
        run_load(3, 7, "gaps");
        check_three("gaps");
    endtask

    task automatic test_zero_and_ignore();
        clear_writes();
        pulse_start(11'd0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL zero_count: done=%b busy=%b in_ready=%b, required 1/0/0", done, busy, in_ready);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (qa.size() != 0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL zero_count_quiet: writes=%0d in_ready=%b, required 0/0", qa.size(), in_ready);
        end
        wbuf[0] = 32'h0BAD_F00D;
        wbuf[1] = 32'hCAFE_0001;
        pulse_start(11'd2);
        send_word(wbuf[0], 0);
        start = 1'b1;
        count = 11'd5;
        @(negedge clk);
        start = 1'b0;
        send_word(wbuf[1], 0);
        send_checksum(wbuf[0] + wbuf[1], 0);
        wait_done("ignore");
        n_checks++;
        if (qa.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL ignore_count: writes=%0d, required 2", qa.size());
        end else begin
            n_checks++;
            if (qa[1] !== 10'd1 || qd[1] !== 32'hCAFE_0001 || qd[0] !== 32'h0BAD_F00D) begin
                n_fail++;
                $display("[TB] FAIL ignore_words: wa1=%h wd0=%h wd1=%h, required 001/0badf00d/cafe0001",
                         qa[1], qd[0], qd[1]);
            end
        end
    endtask

    task automatic test_full_depth();
        int bad = 0;
        for (int i = 0; i < 1024; i++) begin
            wbuf[i] = {16'hC0DE, 6'b0, i[9:0]};
        end
        run_load(1024, 0, "full");
        n_checks++;
        if (qa.size() != 1024) begin
            n_fail++;
            $display("[TB] FAIL full_count: writes=%0d, required 1024", qa.size());
        end else begin
            for (int i = 0; i < 1024; i++) begin
                if (qa[i] !== i[AW-1:0] || qd[i] !== wbuf[i]) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("[TB] FAIL full_sequence: %0d bad writes, required 0", bad);
            end
            n_checks++;
            if (qa[1023] !== 10'h3FF || qd[1023] !== 32'hC0DE_03FF) begin
                n_fail++;
                $display("[TB] FAIL full_last: wa=%h wd=%h, required 3ff/c0de03ff", qa[1023], qd[1023]);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || wa !== 10'h3FF) begin
            n_fail++;
            $display("[TB] FAIL full_end: busy=%b wa=%h, required 0/3ff", busy, wa);
        end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum();
        clear_writes();
        pulse_start(11'd2);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'd3, 0);
        wait_done("csum_ok");
        n_checks++;
        if (err !== 1'b0 || qa.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL csum_ok: err=%b writes=%0d, required 0/2", err, qa.size());
        end
        clear_writes();
        pulse_start(11'd2);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'd4, 0);
        wait_done("csum_bad");
        n_checks++;
        if (err !== 1'b1 || qa.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL csum_bad: err=%b writes=%0d, required 1/2", err, qa.size());
        end
        pulse_start(11'd1);
        n_checks++;
        if (err !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL csum_clear: err=%b done=%b, required 0/0", err, done);
        end
        send_word(32'd9, 0);
        send_word(32'd9, 0);
        wait_done("csum_after");
    endtask
`else
    task automatic test_checksum();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL err_tied: err=%b, required 0", err);
        end
    endtask
`endif

    // Scenario sequence
    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_gaps();
        test_zero_and_ignore();
        test_full_depth();
        test_checksum();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
